// File: rtl/mc_proc_core.sv
// Multi-cycle 32-bit-instruction MIPS-subset core with internal imem/dmem and a shared ALU.
// Latency: j/halt 2 cycles, beq 3, sw/R-type/addi 4, lw 5; illegal ops trap to HALT.
// Backpressure: none; prog=1 parks the core in IDLE and opens imem for loading.
module mc_proc_core #(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 5,
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog,
  input  logic               write,
  input  logic [IMEM_AW-1:0] addr,
  input  logic [31:0]        data_i,
  input  logic [REG_AW-1:0]  dbg_reg,
  output logic [DATA_W-1:0]  dbg_rdata,
  output logic [IMEM_AW-1:0] pc_o,
  output logic               halted,
  output logic               illegal,
  output logic [15:0]        retired
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // R-type function codes
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_NOR = 6'b100111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_nxt;

  // Architectural and pipeline-holding registers
  logic [IMEM_AW-1:0] pc_q;
  logic [31:0]        ir_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [DATA_W-1:0]  aluout_q;
  logic [DATA_W-1:0]  mdr_q;
  logic               illegal_q;
  logic [15:0]        retired_q;

  logic [DATA_W-1:0]  regs [2**REG_AW];
  logic [31:0]        imem [2**IMEM_AW];
  logic [DATA_W-1:0]  dmem [2**DMEM_AW];

  // Instruction fields, decoded from the held IR
  logic [5:0]         op;
  logic [5:0]         funct;
  logic [REG_AW-1:0]  rs;
  logic [REG_AW-1:0]  rt;
  logic [REG_AW-1:0]  rd;
  logic [DATA_W-1:0]  imm_d;
  logic [IMEM_AW-1:0] imm_p;
  logic [DMEM_AW-1:0] dm_addr;

  assign op      = ir_q[31:26];
  assign funct   = ir_q[5:0];
  assign rs      = ir_q[21 +: REG_AW];
  assign rt      = ir_q[16 +: REG_AW];
  assign rd      = ir_q[11 +: REG_AW];
  // Sign-extended immediate, sized once for the ALU and once for branch offsets
  assign imm_d   = DATA_W'($signed(ir_q[15:0]));
  assign imm_p   = IMEM_AW'($signed(ir_q[15:0]));
  // Data address: ALUOUT truncated or zero-extended to the dmem index width
  assign dm_addr = DMEM_AW'(aluout_q);

  // Control strobes produced by the FSM
  logic ir_ld, ab_ld, alu_ld, mdr_ld, reg_we, dmem_we;
  logic retire, set_ill, pc_inc, pc_jmp, pc_br;

  // ALU result and R-type funct legality
  logic [DATA_W-1:0] alu_y;
  logic              funct_ok;

  // Register-file write port (WB stage)
  logic [REG_AW-1:0] reg_wa;
  logic [DATA_W-1:0] reg_wd;

  // Shared ALU: R-type ops by funct, everything else computes A + imm
  always_comb begin
    alu_y    = '0;
    funct_ok = 1'b0;
    if (op == OP_RTYPE) begin
      funct_ok = 1'b1;
      case (funct)
        F_ADD:   alu_y = a_q + b_q;
        F_SUB:   alu_y = a_q - b_q;
        F_AND:   alu_y = a_q & b_q;
        F_OR:    alu_y = a_q | b_q;
        F_NOR:   alu_y = ~(a_q | b_q);
        F_SLT:   alu_y = ($signed(a_q) < $signed(b_q)) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
        default: funct_ok = 1'b0;
      endcase
    end else begin
      alu_y = a_q + imm_d;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-state control strobes; prog overrides everything and suppresses side effects
  always_comb begin
    state_nxt = state;
    ir_ld     = 1'b0;
    ab_ld     = 1'b0;
    alu_ld    = 1'b0;
    mdr_ld    = 1'b0;
    reg_we    = 1'b0;
    dmem_we   = 1'b0;
    retire    = 1'b0;
    set_ill   = 1'b0;
    pc_inc    = 1'b0;
    pc_jmp    = 1'b0;
    pc_br     = 1'b0;
    if (prog) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_FETCH;
        S_FETCH: begin
          ir_ld     = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_DECODE;
        end
        S_DECODE: begin
          ab_ld = 1'b1;
          case (op)
            OP_J: begin
              pc_jmp    = 1'b1;
              retire    = 1'b1;
              state_nxt = S_FETCH;
            end
            OP_HALT: begin
              retire    = 1'b1;
              state_nxt = S_HALT;
            end
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_nxt = S_EXEC;
            default: begin
              set_ill   = 1'b1;
              state_nxt = S_HALT;
            end
          endcase
        end
        S_EXEC: begin
          case (op)
            OP_RTYPE: begin
              if (funct_ok) begin
                alu_ld    = 1'b1;
                state_nxt = S_WB;
              end else begin
                set_ill   = 1'b1;
                state_nxt = S_HALT;
              end
            end
            OP_ADDI: begin
              alu_ld    = 1'b1;
              state_nxt = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_ld    = 1'b1;
              state_nxt = S_MEM;
            end
            OP_BEQ: begin
              pc_br     = (a_q == b_q);
              retire    = 1'b1;
              state_nxt = S_FETCH;
            end
            default: begin
              // Not reachable: DECODE only forwards known opcodes
              set_ill   = 1'b1;
              state_nxt = S_HALT;
            end
          endcase
        end
        S_MEM: begin
          if (op == OP_LW) begin
            mdr_ld    = 1'b1;
            state_nxt = S_WB;
          end else begin
            dmem_we   = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
        end
        S_WB: begin
          reg_we    = 1'b1;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Program counter: cleared by prog, advanced in FETCH, redirected by j and taken beq
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pc_q <= '0;
    else if (prog)   pc_q <= '0;
    else if (pc_inc) pc_q <= pc_q + 1'b1;
    else if (pc_jmp) pc_q <= ir_q[IMEM_AW-1:0];
    else if (pc_br)  pc_q <= pc_q + imm_p;
  end

  // Datapath holding registers IR/A/B/ALUOUT/MDR; r0 always reads as zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      if (ir_ld)  ir_q     <= imem[pc_q];
      if (ab_ld) begin
        a_q <= (rs == '0) ? '0 : regs[rs];
        b_q <= (rt == '0) ? '0 : regs[rt];
      end
      if (alu_ld) aluout_q <= alu_y;
      if (mdr_ld) mdr_q    <= dmem[dm_addr];
    end
  end

  // WB destination: rd for R-type, rt for addi/lw; data from MDR only for lw
  assign reg_wa = (op == OP_RTYPE) ? rd : rt;
  assign reg_wd = (op == OP_LW) ? mdr_q : aluout_q;

  // Register file: cleared on reset, writes to r0 dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
    end else if (reg_we && (reg_wa != '0)) begin
      regs[reg_wa] <= reg_wd;
    end
  end

  // Instruction memory load port, only open in program mode
  always_ff @(posedge clk) begin
    if (prog && write) imem[addr] <= data_i;
  end

  // Data memory store port (sw in MEM)
  always_ff @(posedge clk) begin
    if (dmem_we) dmem[dm_addr] <= b_q;
  end

  // Sticky trap flag and retired-instruction counter; prog clears the flag but holds the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (prog)         illegal_q <= 1'b0;
      else if (set_ill) illegal_q <= 1'b1;
      if (retire)       retired_q <= retired_q + 16'd1;
    end
  end

  assign dbg_rdata = (dbg_reg == '0) ? '0 : regs[dbg_reg];
  assign pc_o      = pc_q;
  assign halted    = (state == S_HALT);
  assign illegal   = illegal_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mc_proc_core.sv
// Directed bench for mc_proc_core: loads small programs, checks registers, PC, flags and counts.
// Latency: cycle-exact checks on instruction timing where the expected count is hand-derived.
// Backpressure: none; all waits on the core are bounded.
module tb_mc_proc_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog;
  logic        write;
  logic [7:0]  addr;
  logic [31:0] data_i;
  logic [4:0]  dbg_reg;
  logic [7:0]  dbg_rdata;
  logic [7:0]  pc_o;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  mc_proc_core #(.DATA_W(8), .REG_AW(5), .IMEM_AW(8), .DMEM_AW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .prog      (prog),
    .write     (write),
    .addr      (addr),
    .data_i    (data_i),
    .dbg_reg   (dbg_reg),
    .dbg_rdata (dbg_rdata),
    .pc_o      (pc_o),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Instruction encoders
  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_r(logic [5:0] fn, int rd, int rs, int rt);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
  endfunction

  function automatic logic [31:0] enc_j(int target);
    return {6'b000010, 26'(target)};
  endfunction

  localparam logic [31:0] HALT_W = 32'hFC00_0000;
  localparam logic [5:0]  OP_ADDI = 6'b001000;
  localparam logic [5:0]  OP_LW   = 6'b100011;
  localparam logic [5:0]  OP_SW   = 6'b101011;
  localparam logic [5:0]  OP_BEQ  = 6'b000100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset with prog held so the core stays parked once reset releases
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    prog  = 1'b1;
    write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load(input int a, input logic [31:0] w);
    @(negedge clk);
    prog   = 1'b1;
    write  = 1'b1;
    addr   = 8'(a);
    data_i = w;
  endtask

  // Ends loading; the first following posedge is IDLE->FETCH
  task automatic start();
    @(negedge clk);
    write = 1'b0;
    prog  = 1'b0;
  endtask

  task automatic rd(input int idx, output logic [7:0] v);
    dbg_reg = 5'(idx);
    #1;
    v = dbg_rdata;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halted && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    reset = 1'b1; prog = 1'b0; write = 1'b0; addr = '0; data_i = '0; dbg_reg = '0;
    #1;
    check("rst_pc", 32'(pc_o), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    rd(1, v); check("rst_r1", 32'(v), 32'd0);

    // 1: addi/addi/add/halt, 15 edges after prog drops
    do_reset();
    load(0, enc_i(OP_ADDI, 0, 1, 5));
    load(1, enc_i(OP_ADDI, 0, 2, 3));
    load(2, enc_r(6'b100000, 3, 1, 2));
    load(3, HALT_W);
    start();
    step(14);
    check("t1_not_yet_halted", 32'(halted), 32'd0);
    check("t1_retired_3", 32'(retired), 32'd3);
    step(1);
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_retired", 32'(retired), 32'd4);
    check("t1_pc", 32'(pc_o), 32'd4);
    check("t1_illegal", 32'(illegal), 32'd0);
    rd(3, v); check("t1_r3", 32'(v), 32'd8);

    // ALU ops with r1=5, r2=3
    do_reset();
    load(0, enc_i(OP_ADDI, 0, 1, 5));
    load(1, enc_i(OP_ADDI, 0, 2, 3));
    load(2, enc_r(6'b100010, 4, 1, 2));
    load(3, enc_r(6'b100100, 5, 1, 2));
    load(4, enc_r(6'b100101, 6, 1, 2));
    load(5, enc_r(6'b100111, 7, 1, 2));
    load(6, enc_r(6'b100010, 8, 2, 1));
    load(7, HALT_W);
    start();
    wait_halt("alu");
    rd(4, v); check("alu_sub", 32'(v), 32'h02);
    rd(5, v); check("alu_and", 32'(v), 32'h01);
    rd(6, v); check("alu_or", 32'(v), 32'h07);
    rd(7, v); check("alu_nor", 32'(v), 32'hF8);
    rd(8, v); check("alu_sub_wrap", 32'(v), 32'hFE);
    check("alu_retired", 32'(retired), 32'd8);

    // 2: 0x7F+1 wraps to 0x80, signed slt
    do_reset();
    load(0, enc_i(OP_ADDI, 0, 1, 16'h7F));
    load(1, enc_i(OP_ADDI, 1, 1, 1));
    load(2, enc_r(6'b101010, 2, 1, 0));
    load(3, enc_r(6'b101010, 3, 0, 1));
    load(4, HALT_W);
    start();
    wait_halt("slt");
    rd(1, v); check("slt_r1", 32'(v), 32'h80);
    rd(2, v); check("slt_neg_lt_0", 32'(v), 32'd1);
    rd(3, v); check("slt_0_lt_neg", 32'(v), 32'd0);

    // 3: sw then lw; lw retires exactly 5 edges after sw retires
    do_reset();
    load(0, enc_i(OP_ADDI, 0, 1, 16'hA5));
    load(1, enc_i(OP_SW, 0, 1, 4));
    load(2, enc_i(OP_LW, 0, 4, 4));
    load(3, HALT_W);
    start();
    step(9);
    check("mem_sw_retired", 32'(retired), 32'd2);
    step(4);
    check("mem_lw_4cyc_retired", 32'(retired), 32'd2);
    rd(4, v); check("mem_lw_4cyc_r4", 32'(v), 32'd0);
    step(1);
    check("mem_lw_5cyc_retired", 32'(retired), 32'd3);
    rd(4, v); check("mem_lw_r4", 32'(v), 32'hA5);
    wait_halt("mem");

    // 4: beq r0,r0,-1 at pc 3 loops every 3 cycles
    do_reset();
    load(0, enc_i(OP_ADDI, 0, 1, 1));
    load(1, enc_i(OP_ADDI, 0, 2, 2));
    load(2, enc_i(OP_ADDI, 0, 3, 3));
    load(3, enc_i(OP_BEQ, 0, 0, 16'hFFFF));
    start();
    step(13);
    check("beq_pc_a", 32'(pc_o), 32'd3);
    check("beq_ret_a", 32'(retired), 32'd3);
    step(1);
    check("beq_pc_fetch", 32'(pc_o), 32'd4);
    step(2);
    check("beq_pc_b", 32'(pc_o), 32'd3);
    check("beq_ret_b", 32'(retired), 32'd4);
    step(3);
    check("beq_pc_c", 32'(pc_o), 32'd3);
    check("beq_ret_c", 32'(retired), 32'd5);
    // prog mid-run: IDLE, pc 0, retired held
    prog = 1'b1;
    step(1);
    check("prog_pc", 32'(pc_o), 32'd0);
    check("prog_halted", 32'(halted), 32'd0);
    step(2);
    check("prog_retired_held", 32'(retired), 32'd5);

    // Untaken beq, then j 0x10 to a halt
    do_reset();
    load(0, enc_i(OP_ADDI, 0, 1, 1));
    load(1, enc_i(OP_BEQ, 1, 0, 5));
    load(2, enc_j(16'h10));
    load(16, HALT_W);
    start();
    step(8);
    check("beq_nt_pc", 32'(pc_o), 32'd2);
    check("beq_nt_ret", 32'(retired), 32'd2);
    step(2);
    check("j_pc", 32'(pc_o), 32'h10);
    check("j_ret", 32'(retired), 32'd3);
    step(2);
    check("j_halted", 32'(halted), 32'd1);
    check("j_halt_pc", 32'(pc_o), 32'h11);
    check("j_halt_ret", 32'(retired), 32'd4);

    // 5: undefined opcode 0x3E at pc 0
    do_reset();
    load(0, 32'hF800_0000);
    start();
    step(2);
    check("ill_op_early", 32'(halted), 32'd0);
    step(1);
    check("ill_op_halted", 32'(halted), 32'd1);
    check("ill_op_flag", 32'(illegal), 32'd1);
    check("ill_op_retired", 32'(retired), 32'd0);

    // addi r0 discarded; undefined funct traps in EXEC; prog clears flags
    do_reset();
    load(0, enc_i(OP_ADDI, 0, 0, 7));
    load(1, enc_i(OP_ADDI, 0, 1, 9));
    load(2, enc_r(6'b000001, 3, 1, 1));
    load(3, HALT_W);
    start();
    wait_halt("ill_fn");
    check("ill_fn_flag", 32'(illegal), 32'd1);
    check("ill_fn_retired", 32'(retired), 32'd2);
    check("ill_fn_pc", 32'(pc_o), 32'd3);
    rd(0, v); check("r0_zero", 32'(v), 32'd0);
    rd(1, v); check("ill_fn_r1", 32'(v), 32'd9);
    rd(3, v); check("ill_fn_r3", 32'(v), 32'd0);
    prog = 1'b1;
    step(1);
    check("prog_clr_halted", 32'(halted), 32'd0);
    check("prog_clr_illegal", 32'(illegal), 32'd0);
    check("prog_clr_retired", 32'(retired), 32'd2);

    // 6: reset during EXEC of lw
    do_reset();
    load(0, enc_i(OP_ADDI, 0, 4, 16'h33));
    load(1, enc_i(OP_LW, 0, 4, 4));
    load(2, HALT_W);
    start();
    step(7);
    rd(4, v); check("rst_mid_pre_r4", 32'(v), 32'h33);
    check("rst_mid_pre_ret", 32'(retired), 32'd1);
    check("rst_mid_pre_pc", 32'(pc_o), 32'd2);
    reset = 1'b1;
    #1;
    check("rst_mid_pc", 32'(pc_o), 32'd0);
    check("rst_mid_ret", 32'(retired), 32'd0);
    rd(4, v); check("rst_mid_r4", 32'(v), 32'd0);
    prog = 1'b1;
    step(1);
    reset = 1'b0;
    step(3);
    rd(4, v); check("rst_mid_r4_after", 32'(v), 32'd0);
    check("rst_mid_pc_after", 32'(pc_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
